multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Moore FSM that sequences the 64-bit multicycle RISC-V datapath: PC, IR, reg bank, A/B, ALU, AluOut, data memory, MemDataReg.
//  Decodes IR opcode/funct fields and drives every load enable, mux select and ALU op, one micro-step per clock.
//  Adds a PC-source select (ALU result vs AluOut) for branches, and a wait counter for memory latency.
// PARAMETERS
//  MEM_LATENCY  1  clocks from address to valid read data, instr and data memory; legal 1..7
// PORTS
//  clk            in   1  clock, rising edge
//  rst            in   1  asynchronous, active-low reset
//  i6_0           in   7  IR opcode
//  funct3         in   3  IR[14:12]
//  funct7         in   7  IR[31:25]
//  alu_zero       in   1  ALU result == 0
//  PCwrite        out  1  load PC
//  SelMuxPC       out  1  PC input: 0=ALU result, 1=AluOut
//  IRwrite        out  1  load IR
//  RegWrite       out  1  write reg bank at rd
//  loadRegA/B     out  1  load A / B (two ports)
//  loadRegAluOut  out  1  load AluOut
//  loadRegMemData out  1  load MemDataReg
//  MemData_Wr     out  1  data memory write strobe
//  SelMux2        out  1  ALU A: 0=PC, 1=A
//  SelMux4        out  2  ALU B: 00=B, 01=4, 10=SignExt, 11=Shift
//  SelMuxMem      out  1  reg write data: 0=AluOut, 1=MemDataReg
//  AluOperation   out  3  000=pass B, 001=add, 010=sub, 011=and
//  state_out      out  4  current state encoding, for debug
//  illegal        out  1  sticky: unsupported opcode seen
// BEHAVIOUR
//  States: RESET=0 FETCH=1 DECODE=2 EXEC_R=3 EXEC_I=4 ADDR=5 MEM_RD=6 MEM_WR=7 WB_ALU=8 WB_MEM=9 BRANCH=10 LUI=11 HALT=12 ILLEGAL=13.
//  Reset (rst=0, async): state=RESET, wait counter=0, illegal=0. Every enable/select/AluOperation=0 whenever state=RESET.
//  RESET -> FETCH on the first clock edge after rst deasserts.
//  Outputs are decoded from state and wait counter only. No combinational path from inputs, except alu_zero in BRANCH.
//  FETCH: SelMux2=0, SelMux4=01, op=001. Held MEM_LATENCY cycles. IRwrite=PCwrite=1 on last cycle only (PC+=4). -> DECODE.
//  DECODE: loadRegA=loadRegB=1. AluOut<=PC+Shift (SelMux2=0, SelMux4=11, op=001, loadRegAluOut=1).
//    Note: PC here already holds PC+4.
//  DECODE dispatch on opcode:
//    0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 or 0100011 -> ADDR;
//    1100011 -> BRANCH; 0110111 -> LUI; 1110011 -> HALT; else -> ILLEGAL.
//  EXEC_R: SelMux2=1, SelMux4=00, loadRegAluOut=1. Op: funct3=000,funct7=0000000 -> 001 (add); funct3=000,funct7=0100000 -> 010 (sub); funct3=111 -> 011 (and). Other funct -> ILLEGAL. -> WB_ALU.
//  EXEC_I: SelMux2=1, SelMux4=10, op=001, loadRegAluOut=1. -> WB_ALU.
//  ADDR: same ALU setup as EXEC_I. -> MEM_RD if opcode=0000011, MEM_WR if 0100011.
//  MEM_RD: held MEM_LATENCY cycles, loadRegMemData=1 on last cycle. -> WB_MEM.
//  MEM_WR: MemData_Wr=1 for exactly 1 cycle, address AluOut, data B. -> FETCH.
//  WB_ALU: RegWrite=1, SelMuxMem=0. -> FETCH.   WB_MEM: RegWrite=1, SelMuxMem=1. -> FETCH.
//  BRANCH: SelMux2=1, SelMux4=00, op=010, SelMuxPC=1.
//    PCwrite = (funct3=000 & alu_zero) | (funct3=001 & ~alu_zero); other funct3 -> ILLEGAL. -> FETCH.
//  LUI: SelMux4=10, op=000, loadRegAluOut=1. -> WB_ALU.
//  HALT and ILLEGAL are absorbing until reset; all enables=0. illegal=1 from entry to ILLEGAL.
//  Wait counter: 3 bits, cleared on entry to FETCH/MEM_RD, +1 per held cycle. Never wraps (max MEM_LATENCY-1).
//  Every write enable (PCwrite, IRwrite, RegWrite, MemData_Wr) asserts for at most 1 cycle per instruction.
//  Reset mid-instruction: immediate return to RESET. No partial write is issued after rst falls.
// TESTING
//  1. Reset during EXEC_R -> next sample state_out=0, all enables 0; after release FETCH, then DECODE.
//  2. Instr add (0110011/000/0000000), MEM_LATENCY=1 -> states 1,2,3,8,1; AluOperation=001 in EXEC_R; RegWrite high 1 cycle.
//  3. Instr sub, then and -> AluOperation 010, then 011; funct3=101 -> ILLEGAL, illegal=1, no RegWrite.
//  4. ld with MEM_LATENCY=3 -> FETCH 3 cycles with IRwrite on 3rd only; MEM_RD 3 cycles, loadRegMemData on 3rd; WB_MEM SelMuxMem=1.
//  5. sd -> states 1,2,5,7,1; MemData_Wr=1 exactly 1 cycle; RegWrite never asserted.
//  6. beq, alu_zero=1 -> PCwrite=1, SelMuxPC=1. beq, alu_zero=0 -> PCwrite=0.
//     bne inverts both. Opcode 1110011 -> HALT held for 100 cycles.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and the 64-bit datapath.
// master: controller (takes IR fields/alu_zero, drives enables, selects, ALU op).
interface multicycle_control_if;
    logic [6:0] i6_0;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alu_zero;
    logic       PCwrite;
    logic       SelMuxPC;
    logic       IRwrite;
    logic       RegWrite;
    logic       loadRegA;
    logic       loadRegB;
    logic       loadRegAluOut;
    logic       loadRegMemData;
    logic       MemData_Wr;
    logic       SelMux2;
    logic [1:0] SelMux4;
    logic       SelMuxMem;
    logic [2:0] AluOperation;
    logic [3:0] state_out;
    logic       illegal;

    modport master (
        input  i6_0, funct3, funct7, alu_zero,
        output PCwrite, SelMuxPC, IRwrite, RegWrite,
        output loadRegA, loadRegB, loadRegAluOut, loadRegMemData,
        output MemData_Wr, SelMux2, SelMux4, SelMuxMem,
        output AluOperation, state_out, illegal
    );

    modport slave (
        output i6_0, funct3, funct7, alu_zero,
        input  PCwrite, SelMuxPC, IRwrite, RegWrite,
        input  loadRegA, loadRegB, loadRegAluOut, loadRegMemData,
        input  MemData_Wr, SelMux2, SelMux4, SelMuxMem,
        input  AluOperation, state_out, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the 64-bit multicycle RISC-V datapath, one micro-step per clock.
// Ports: clk, rst (async active-low), bus (master: IR fields in, controls out).
module multicycle_control #(
    parameter int MEM_LATENCY = 1
) (
    input logic                 clk,
    input logic                 rst,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_EXEC_I  = 4'd4,
        S_ADDR    = 4'd5,
        S_MEM_RD  = 4'd6,
        S_MEM_WR  = 4'd7,
        S_WB_ALU  = 4'd8,
        S_WB_MEM  = 4'd9,
        S_BRANCH  = 4'd10,
        S_LUI     = 4'd11,
        S_HALT    = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_wr;
        logic       sel_pc;
        logic       ir_wr;
        logic       reg_wr;
        logic       ld_a;
        logic       ld_b;
        logic       ld_alu;
        logic       ld_mem;
        logic       mem_wr;
        logic       sel2;
        logic [1:0] sel4;
        logic       sel_mem;
        logic [2:0] op;
        logic       beq;
        logic       bne;
    } ctl_t;

    localparam logic [2:0] LAST = 3'(MEM_LATENCY - 1);

    state_t     st, ns;
    logic [2:0] wcnt, nw;
    ctl_t       c_q, c_d;
    logic       illegal_q;

    logic r_add, r_sub, r_and;

    assign r_add = (bus.funct3 == 3'b000) && (bus.funct7 == 7'b0000000);
    assign r_sub = (bus.funct3 == 3'b000) && (bus.funct7 == 7'b0100000);
    assign r_and = (bus.funct3 == 3'b111);

    // Outputs are computed for the state being entered and registered,
    // so everything except the branch decision is a flop output.
    always_comb begin
        ns  = st;
        nw  = '0;
        c_d = '0;

        unique case (st)
            S_RESET:  ns = S_FETCH;
            S_FETCH: begin
                if (wcnt == LAST) begin
                    ns = S_DECODE;
                end else begin
                    nw = wcnt + 3'd1;
                end
            end
            S_DECODE: begin
                case (bus.i6_0)
                    7'b0110011: ns = S_EXEC_R;
                    7'b0010011: ns = S_EXEC_I;
                    7'b0000011: ns = S_ADDR;
                    7'b0100011: ns = S_ADDR;
                    7'b1100011: ns = S_BRANCH;
                    7'b0110111: ns = S_LUI;
                    7'b1110011: ns = S_HALT;
                    default:    ns = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: ns = (r_add | r_sub | r_and) ? S_WB_ALU : S_ILLEGAL;
            S_EXEC_I: ns = S_WB_ALU;
            S_ADDR:   ns = (bus.i6_0 == 7'b0000011) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (wcnt == LAST) begin
                    ns = S_WB_MEM;
                end else begin
                    nw = wcnt + 3'd1;
                end
            end
            S_MEM_WR: ns = S_FETCH;
            S_WB_ALU: ns = S_FETCH;
            S_WB_MEM: ns = S_FETCH;
            S_BRANCH: begin
                ns = (bus.funct3[2:1] == 2'b00) ? S_FETCH : S_ILLEGAL;
            end
            S_LUI:     ns = S_WB_ALU;
            S_HALT:    ns = S_HALT;
            S_ILLEGAL: ns = S_ILLEGAL;
            default:   ns = S_ILLEGAL;
        endcase

        unique case (ns)
            S_FETCH: begin
                c_d.sel4  = 2'b01;
                c_d.op    = 3'b001;
                c_d.ir_wr = (nw == LAST);
                c_d.pc_wr = (nw == LAST);
            end
            S_DECODE: begin
                c_d.ld_a   = 1'b1;
                c_d.ld_b   = 1'b1;
                c_d.ld_alu = 1'b1;
                c_d.sel4   = 2'b11;
                c_d.op     = 3'b001;
            end
            S_EXEC_R: begin
                c_d.sel2   = 1'b1;
                c_d.ld_alu = 1'b1;
                unique case (1'b1)
                    r_add:   c_d.op = 3'b001;
                    r_sub:   c_d.op = 3'b010;
                    r_and:   c_d.op = 3'b011;
                    default: c_d.op = 3'b000;
                endcase
            end
            S_EXEC_I, S_ADDR: begin
                c_d.sel2   = 1'b1;
                c_d.sel4   = 2'b10;
                c_d.op     = 3'b001;
                c_d.ld_alu = 1'b1;
            end
            S_MEM_RD: c_d.ld_mem = (nw == LAST);
            S_MEM_WR: c_d.mem_wr = 1'b1;
            S_WB_ALU: c_d.reg_wr = 1'b1;
            S_WB_MEM: begin
                c_d.reg_wr  = 1'b1;
                c_d.sel_mem = 1'b1;
            end
            S_BRANCH: begin
                c_d.sel2   = 1'b1;
                c_d.op     = 3'b010;
                c_d.sel_pc = 1'b1;
                c_d.beq    = (bus.funct3 == 3'b000);
                c_d.bne    = (bus.funct3 == 3'b001);
            end
            S_LUI: begin
                c_d.sel4   = 2'b10;
                c_d.ld_alu = 1'b1;
            end
            default: c_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= S_RESET;
            wcnt      <= '0;
            c_q       <= '0;
            illegal_q <= 1'b0;
        end else begin
            st        <= ns;
            wcnt      <= nw;
            c_q       <= c_d;
            illegal_q <= illegal_q | (ns == S_ILLEGAL);
        end
    end

    // Branch outcome is the only input that reaches an output directly.
    assign bus.PCwrite = c_q.pc_wr |
        ((st == S_BRANCH) &
         ((c_q.beq & bus.alu_zero) | (c_q.bne & ~bus.alu_zero)));

    assign bus.SelMuxPC       = c_q.sel_pc;
    assign bus.IRwrite        = c_q.ir_wr;
    assign bus.RegWrite       = c_q.reg_wr;
    assign bus.loadRegA       = c_q.ld_a;
    assign bus.loadRegB       = c_q.ld_b;
    assign bus.loadRegAluOut  = c_q.ld_alu;
    assign bus.loadRegMemData = c_q.ld_mem;
    assign bus.MemData_Wr     = c_q.mem_wr;
    assign bus.SelMux2        = c_q.sel2;
    assign bus.SelMux4        = c_q.sel4;
    assign bus.SelMuxMem      = c_q.sel_mem;
    assign bus.AluOperation   = c_q.op;
    assign bus.state_out      = st;
    assign bus.illegal        = illegal_q;

endmodule
